// File: rtl/hcs_pkg.sv
// Shared constants for the alarm reporter: header byte, serializer states,
// flag positions inside the status byte and frame geometry.
package hcs_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_e;

  // Flag bits occupy the upper nibble; glycemic index sits in [3:0]
  localparam int FALL_BIT  = 7;
  localparam int TEMP_BIT  = 6;
  localparam int BLOOD_BIT = 5;
  localparam int PRES_BIT  = 4;

  localparam int FRAME_BYTES = 3;

  function automatic logic [7:0] frameChecksum(input logic [7:0] hdr, input logic [7:0] status);
    return hdr ^ status;
  endfunction

endpackage

// File: rtl/hcs_uart_tx.sv
// 8N1 byte serializer. byteReady is also raised in the last stop-bit cycle so
// consecutive bytes leave the line with no idle gap.
module hcs_uart_tx
  import hcs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byteValid,
  input  logic [7:0] byteData,
  output logic       byteReady,
  output logic       txBusy,
  output logic       txSerial
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

  txState_e      state;
  logic [CW-1:0] clkCnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;
  logic          txReg;
  logic          bitDone;

  assign bitDone   = (clkCnt == CLK_LAST);
  assign byteReady = (state == IDLE) || ((state == STOP) && bitDone);
  assign txBusy    = (state != IDLE);
  assign txSerial  = txReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clkCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
    end else if (byteValid && byteReady) begin
      state    <= START;
      clkCnt   <= '0;
      shiftReg <= byteData;
      txReg    <= 1'b0;
    end else begin
      case (state)
        IDLE: txReg <= 1'b1;
        START: begin
          if (bitDone) begin
            clkCnt <= '0;
            bitIdx <= '0;
            state  <= DATA;
            txReg  <= shiftReg[0];
          end else begin
            clkCnt <= clkCnt + CW'(1);
          end
        end
        DATA: begin
          if (bitDone) begin
            clkCnt <= '0;
            if (bitIdx == 3'd7) begin
              state <= STOP;
              txReg <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              shiftReg <= shiftReg >> 1;
              txReg    <= shiftReg[1];
            end
          end else begin
            clkCnt <= clkCnt + CW'(1);
          end
        end
        STOP: begin
          if (bitDone) begin
            clkCnt <= '0;
            state  <= IDLE;
          end else begin
            clkCnt <= clkCnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hcs_alarm_reporter.sv
// Debounces the healthCareSystem status and reports every stable change (or
// requested snapshot) as a 3-byte frame: header, status, header^status.
module hcs_alarm_reporter
  import hcs_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         DEBOUNCE     = 16,
  parameter logic [7:0] HDR          = HDR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       presure_abnormality,
  input  logic       blood_abnormality,
  input  logic       fall_detected,
  input  logic       temperature_abnormality,
  input  logic [3:0] glycemic_index,
  input  logic       report_req,
  output logic       tx_serial,
  output logic       busy,
  output logic       alarm,
  output logic [7:0] stable_status,
  output logic [7:0] overrun_count
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(FRAME_BYTES - 1);

  logic [7:0]    rawStatus, sPrev, stableReg, pending, frameStatus, snapshot, byteData;
  logic [7:0]    overrunReg;
  logic [DW-1:0] debCnt;
  logic [1:0]    byteIdx;
  logic          pendingValid, debEvent, evt;
  logic          lineFree, launchPending, launchDirect;
  logic          byteValid, byteReady, txBusy;

  always_comb begin
    rawStatus            = {4'b0000, glycemic_index};
    rawStatus[FALL_BIT]  = fall_detected;
    rawStatus[TEMP_BIT]  = temperature_abnormality;
    rawStatus[BLOOD_BIT] = blood_abnormality;
    rawStatus[PRES_BIT]  = presure_abnormality;
  end

  // byteIdx names the next frame byte still to hand over; 0 means none left
  always_comb begin
    debEvent      = (debCnt == DEB_LAST) && (sPrev != stableReg);
    evt           = debEvent || report_req;
    snapshot      = debEvent ? sPrev : stableReg;
    lineFree      = byteReady && (byteIdx == 2'd0);
    launchPending = lineFree && pendingValid;
    launchDirect  = !txBusy && !pendingValid && evt;
    byteValid     = (byteIdx != 2'd0) || launchPending || launchDirect;
    case (byteIdx)
      2'd1:    byteData = frameStatus;
      2'd2:    byteData = frameChecksum(HDR, frameStatus);
      default: byteData = HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sPrev        <= '0;
      debCnt       <= '0;
      stableReg    <= '0;
      pending      <= '0;
      pendingValid <= 1'b0;
      overrunReg   <= '0;
      frameStatus  <= '0;
      byteIdx      <= '0;
    end else begin
      sPrev <= rawStatus;
      if (rawStatus != sPrev) begin
        debCnt <= '0;
      end else if (debCnt != DEB_LAST) begin
        debCnt <= debCnt + DW'(1);
      end
      if (debEvent) begin
        stableReg <= sPrev;
      end

      if (byteValid && byteReady) begin
        if (byteIdx == 2'd0) begin
          frameStatus <= launchPending ? pending : snapshot;
          byteIdx     <= 2'd1;
        end else begin
          byteIdx <= (byteIdx == LAST_BYTE) ? 2'd0 : byteIdx + 2'd1;
        end
      end

      // A snapshot arriving as the pending one launches simply refills the slot
      if (evt && !launchDirect) begin
        pending      <= snapshot;
        pendingValid <= 1'b1;
        if (pendingValid && !launchPending && (overrunReg != 8'hFF)) begin
          overrunReg <= overrunReg + 8'd1;
        end
      end else if (launchPending) begin
        pendingValid <= 1'b0;
      end
    end
  end

  hcs_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uartTx (
    .clk      (clk),
    .rst      (rst),
    .byteValid(byteValid),
    .byteData (byteData),
    .byteReady(byteReady),
    .txBusy   (txBusy),
    .txSerial (tx_serial)
  );

  assign busy          = txBusy;
  assign stable_status = stableReg;
  assign overrun_count = overrunReg;
  assign alarm = stableReg[FALL_BIT] | stableReg[TEMP_BIT] | stableReg[BLOOD_BIT] | stableReg[PRES_BIT];

endmodule

// File: doc/hcs_alarm_reporter.md
Name: hcs_alarm_reporter

Overview:
Consumer end of the healthCareSystem output interface. Samples the four abnormality flags and glycemicIndex every cycle, debounces the combined status, and keeps a stable copy. On every stable change, or on request, it sends a 3-byte alarm frame over an 8N1 UART line to the nurse-station link. One snapshot can be held pending while a frame is in flight; overruns are counted.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (minimum 2)
DEBOUNCE, 16, consecutive identical samples required before a status is accepted (minimum 1)
HDR, 8'hA5, frame header byte

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
presure_abnormality  input  1  from healthCareSystem
blood_abnormality  input  1  from healthCareSystem
fall_detected  input  1  from healthCareSystem
temperature_abnormality  input  1  from healthCareSystem
glycemic_index  input  4  from healthCareSystem
report_req  input  1  single-cycle pulse that forces a frame carrying the current stable status
tx_serial  output  1  UART line, idle high
busy  output  1  frame in flight
alarm  output  1  OR of the four flag bits of stable_status
stable_status  output  8  debounced status
overrun_count  output  8  saturating count of overwritten pending snapshots

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: tx_serial=1, busy=0, alarm=0, stable_status=8'h00, overrun_count=0. Pending slot is cleared and the FSM is in IDLE. Reset mid-frame aborts the frame immediately and the line returns high.
- Raw status S = {fall_detected, temperature_abnormality, blood_abnormality, presure_abnormality, glycemic_index}.
- Debounce: register S_prev and cnt.
  - If S != S_prev, cnt <= 0.
  - Otherwise cnt increments and saturates at DEBOUNCE-1.
  - When cnt == DEBOUNCE-1 and S_prev != stable_status, then stable_status <= S_prev and an event fires in the same cycle.
  - Result: stable_status updates DEBOUNCE+1 edges after S first changes. A glitch shorter than DEBOUNCE samples never updates stable_status.
- Event sources: a debounce event, or report_req=1, which snapshots the current stable_status. If both occur in the same cycle, a single event carries the new status.
- Event handling:
  - FSM IDLE with no pending: load the frame, busy=1 on the next edge.
  - Otherwise: pending <= snapshot, pending_valid=1.
  - If pending_valid was already 1, the new snapshot overwrites it and overrun_count increments, saturating at 255.
- Frame is 3 bytes: HDR, status, HDR^status. Each byte is sent as a start bit (0), 8 data bits LSB first, then a stop bit (1). Every bit lasts CLKS_PER_BIT cycles. Frame length = 30*CLKS_PER_BIT cycles.
- FSM states:
  - IDLE -> START on load.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START for the next byte while byte_idx<2.
  - STOP -> IDLE after byte 2; if pending_valid, it loads pending instead, clears it, and goes straight to START with no idle gap.
- busy is high from the first start-bit cycle through the last stop-bit cycle, including back-to-back frames.
- alarm is combinational from stable_status[7:4].
- All counters are sized with $clog2 of their parameter bound. There is no wrap-around except the byte and bit indices, which are reset per byte and per frame.

Decomposition:
- Shared package hcs_pkg: HDR default, FSM state encoding (IDLE/START/DATA/STOP), flag bit positions within the status byte, frame length constant.
- One sub-module, hcs_uart_tx: byte serializer with byte_valid/byte_ready handshake and a CLKS_PER_BIT parameter.
- The top level owns debounce, the pending slot, the frame byte sequencing and checksum.

Test Plan (CLKS_PER_BIT=4, DEBOUNCE=3):
1. Reset mid-frame: assert rst during the DATA state -> tx_serial=1, busy=0, stable_status=00, overrun_count=0 asynchronously.
2. Hold fall_detected=1, glycemic_index=4'h6 -> stable_status=8'h86 after 4 edges, alarm=1. The line then carries A5, 86, 23 LSB-first over 120 cycles.
3. One-cycle pulse on blood_abnormality, then two cycles of pressure=1 -> stable_status unchanged, no frame.
4. Change the status mid-frame, then again before the frame ends -> one overrun (overrun_count=1). The second frame follows with no idle gap and carries the last snapshot.
5. report_req with stable_status=00 while idle -> frame A5, 00, A5.
6. report_req coincident with a debounce event -> exactly one frame, carrying the new status.
